// File: rtl/md_scheduler_if.sv
// Multiply/divide unit interface: E-stage issue, D-stage MD-class flag, HI/LO and status.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  modport master (output start, op, a, b, d_is_md,
                  input  busy, done, hi, lo, md_stall);
  modport slave  (input  start, op, a, b, d_is_md,
                  output busy, done, hi, lo, md_stall);
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer holding HI/LO with a fixed-latency busy countdown.
// Optional MD_EARLY_OUT_EN: zero-operand mult/div completes after one busy cycle.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic             busy_q, done_q;

  logic        signed_op;
  logic        a_neg, b_neg, div_by_zero;
  logic [63:0] mul_res;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Countdown load value chosen from the issuing op
  always_comb begin
    cnt_d = md.op[1] ? DIV_LOAD : MULT_LOAD;
`ifdef MD_EARLY_OUT_EN
    if (md.op[1] ? ((md.a == '0) && (md.b != '0)) : ((md.a == '0) || (md.b == '0)))
      cnt_d = '0;
`endif
  end

  // Result datapath from latched operands; division via magnitudes so the
  // 0x80000000 / -1 case wraps to 0x80000000 with zero remainder
  always_comb begin
    signed_op   = ~op_q[0];
    a_neg       = signed_op & a_q[31];
    b_neg       = signed_op & b_q[31];
    mul_res     = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
    a_mag       = a_neg ? (32'd0 - a_q) : a_q;
    b_mag       = b_neg ? (32'd0 - b_q) : b_q;
    div_by_zero = (b_q == '0);
    b_safe      = div_by_zero ? 32'd1 : b_mag;
    q_mag       = a_mag / b_safe;
    r_mag       = a_mag % b_safe;
    quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md.start) begin
            case (md.op)
              OP_MTHI: hi_q <= md.a;
              OP_MTLO: lo_q <= md.a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= md.op[1:0];
                a_q     <= md.a;
                b_q     <= md.b;
                cnt_q   <= cnt_d;
                busy_q  <= 1'b1;
                state_q <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!op_q[1]) begin
              {hi_q, lo_q} <= mul_res;
            end else if (!div_by_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = md.d_is_md & (busy_q | (md.start & ~md.op[2]));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed cases plus random ops against a reference model.
module tb_md_scheduler;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_scheduler_if md ();

  md_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat;
    lat = (op < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
`ifdef MD_EARLY_OUT_EN
    if (op < 3'd2 && (a == 0 || b == 0)) lat = 1;
    if (op >= 3'd2 && a == 0 && b != 0) lat = 1;
`endif
    return lat;
  endfunction

  // Architectural effect of one op on HI/LO
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue one op and follow it to completion; returns on the done cycle
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit dmd, input bit inject, input string tag);
    int unsigned lat;
    int unsigned n;
    md.start = 1'b1; md.op = op; md.a = a; md.b = b; md.d_is_md = dmd;
    #1;
    check({tag, " stall_start"}, 32'(md.md_stall), 32'(dmd && op < 3'd4));
    lat = latency(op, a, b);
    @(posedge clk); #1;
    md.start = 1'b0;
    if (op < 3'd4) begin
      n = 0;
      while (md.busy === 1'b1 && n < 64) begin
        check({tag, " stall_busy"}, 32'(md.md_stall), 32'(dmd));
        check({tag, " done_low"}, 32'(md.done), 32'd0);
        check({tag, " hi_hold"}, md.hi, hi_m);
        check({tag, " lo_hold"}, md.lo, lo_m);
        n++;
        if (inject && n == 2) begin
          md.start = 1'b1; md.op = 3'd5; md.a = 32'd9;
        end else begin
          md.start = 1'b0;
        end
        @(posedge clk); #1;
      end
      md.start = 1'b0;
      check({tag, " busy_cycles"}, n, lat);
      model(op, a, b);
      check({tag, " done"}, 32'(md.done), 32'd1);
    end else begin
      model(op, a, b);
      check({tag, " busy_idle"}, 32'(md.busy), 32'd0);
      check({tag, " done_idle"}, 32'(md.done), 32'd0);
    end
    check({tag, " hi"}, md.hi, hi_m);
    check({tag, " lo"}, md.lo, lo_m);
    md.d_is_md = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int unsigned sel;

    reset = 1'b0;
    md.start = 1'b0; md.op = '0; md.a = '0; md.b = '0; md.d_is_md = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(md.busy), 32'd0);
    check("reset done", 32'(md.done), 32'd0);
    check("reset hi", md.hi, 32'd0);
    check("reset lo", md.lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult_neg");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    do_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0, "divu");
    do_op(3'd4, 32'h11, 32'h0, 1'b0, 1'b0, "mthi");
    do_op(3'd5, 32'h22, 32'h0, 1'b0, 1'b0, "mtlo");
    do_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0, "div_zero");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "multu_stall");
    do_op(3'd6, 32'h1234, 32'h0, 1'b1, 1'b0, "reserved6");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    do_op(3'd0, 32'd0, 32'd123, 1'b0, 1'b0, "mult_zero");
    do_op(3'd2, 32'd0, 32'd7, 1'b0, 1'b0, "div_a_zero");

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) ra = 32'd0;
      if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    // Abort an in-flight divide with reset
    do_op(3'd4, 32'h55, 32'h0, 1'b0, 1'b0, "pre_hi");
    do_op(3'd5, 32'h66, 32'h0, 1'b0, 1'b0, "pre_lo");
    md.start = 1'b1; md.op = 3'd2; md.a = 32'd100; md.b = 32'd3;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort busy_before", 32'(md.busy), 32'd1);
    reset = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("abort busy", 32'(md.busy), 32'd0);
    check("abort done", 32'(md.done), 32'd0);
    check("abort hi", md.hi, hi_m);
    check("abort lo", md.lo, lo_m);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_reset busy", 32'(md.busy), 32'd0);
      check("post_reset done", 32'(md.done), 32'd0);
    end
    check("post_reset hi", md.hi, hi_m);
    check("post_reset lo", md.lo, lo_m);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
